// File: rtl/cv32e40p_apu_core_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_core_pkg
//   Shared APU/FPU interface widths used by the core-side and APU-side ports
//   of the APU arbiter, plus a helper for sizing core-index fields.
// -----------------------------------------------------------------------------
package cv32e40p_apu_core_pkg;

    localparam int unsigned APU_NARGS_CPU    = 3;
    localparam int unsigned APU_WOP_CPU      = 6;
    localparam int unsigned APU_NDSFLAGS_CPU = 15;
    localparam int unsigned APU_NUSFLAGS_CPU = 5;

    // Width of a core index; a single core still needs a 1-bit field.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cv32e40p_apu_id_fifo.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_id_fifo
//   In-order tracker of which core issued each in-flight APU request.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset (empties the FIFO)
//     push_i, data_i  enqueue a core index (ignored when full)
//     pop_i           dequeue the head entry (ignored when empty)
//     full_o, empty_o occupancy status
//     head_o          oldest entry (valid when not empty)
// -----------------------------------------------------------------------------
module cv32e40p_apu_id_fifo #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]                 cnt_q;
    logic                             push_en, pop_en;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count says valid.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_arbiter
//   Shares one APU/FPU between NUM_CORES cores. Requests are arbitrated
//   round-robin and granted with zero latency; the granting core's index is
//   queued so in-order APU responses are routed back to the right core.
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     core_apu_*_i / _o      per-core request side (req/gnt, payload, rvalid)
//     core_apu_result_o      result, broadcast to all cores
//     core_apu_flags_o       upstream flags, broadcast to all cores
//     apu_*_o / _i           single shared APU port
//     err_o                  sticky: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module cv32e40p_apu_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int unsigned NUM_CORES       = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_ni,

    input  logic [NUM_CORES-1:0]                                 core_apu_req_i,
    output logic [NUM_CORES-1:0]                                 core_apu_gnt_o,
    input  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0]        core_apu_operands_i,
    input  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]                core_apu_op_i,
    input  logic [NUM_CORES-1:0][2:0]                            core_apu_type_i,
    input  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]           core_apu_flags_i,
    output logic [NUM_CORES-1:0]                                 core_apu_rvalid_o,
    output logic [31:0]                                          core_apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                          core_apu_flags_o,

    output logic                                                 apu_req_o,
    input  logic                                                 apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                       apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                               apu_op_o,
    output logic [2:0]                                           apu_type_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                          apu_flags_o,
    input  logic                                                 apu_rvalid_i,
    input  logic [31:0]                                          apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                          apu_flags_i,

    output logic                                                 err_o
);

    localparam int unsigned IDX_W = idx_width(NUM_CORES);

    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] fifo_head;
    logic             any_req;
    logic             handshake;
    logic             pop;
    logic             fifo_full, fifo_empty;
    logic             err_q, err_d;

    // Round-robin search starting at rr_q.
    always_comb begin
        int unsigned idx;
        logic        found;
        winner = rr_q;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = (32'(rr_q) + i) % NUM_CORES;
            if (!found && core_apu_req_i[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_req = |core_apu_req_i;

    // A full tracker blocks new requests even if a response frees a slot
    // this cycle; gating with rst_ni keeps grants low while reset is held.
    assign apu_req_o = rst_ni & any_req & ~fifo_full;
    assign handshake = apu_req_o & apu_gnt_i;

    always_comb begin
        core_apu_gnt_o = '0;
        if (handshake) begin
            core_apu_gnt_o[winner] = 1'b1;
        end
    end

    always_comb begin
        apu_operands_o = '0;
        apu_op_o       = '0;
        apu_type_o     = '0;
        apu_flags_o    = '0;
        if (any_req) begin
            apu_operands_o = core_apu_operands_i[winner];
            apu_op_o       = core_apu_op_i[winner];
            apu_type_o     = core_apu_type_i[winner];
            apu_flags_o    = core_apu_flags_i[winner];
        end
    end

    // Responses return in issue order, so the FIFO head names the owner.
    assign pop = rst_ni & apu_rvalid_i & ~fifo_empty;

    always_comb begin
        core_apu_rvalid_o = '0;
        if (pop) begin
            core_apu_rvalid_o[fifo_head] = 1'b1;
        end
    end

    assign core_apu_result_o = apu_result_i;
    assign core_apu_flags_o  = apu_flags_i;

    always_comb begin
        rr_d = rr_q;
        if (handshake) begin
            if (winner == IDX_W'(NUM_CORES - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = winner + IDX_W'(1);
            end
        end
    end

    assign err_d = err_q | (apu_rvalid_i & fifo_empty);
    assign err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    cv32e40p_apu_id_fifo #(
        .DEPTH      (MAX_OUTSTANDING),
        .DATA_WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .pop_i   (pop),
        .data_i  (winner),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_apu_arbiter
//   Directed-vector bench for the two-core, four-deep APU arbiter.
// -----------------------------------------------------------------------------
module tb_cv32e40p_apu_arbiter;
    import cv32e40p_apu_core_pkg::*;

    localparam int unsigned NC = 2;

    logic                                          clk;
    logic                                          rst_ni;
    logic [NC-1:0]                                 core_apu_req_i;
    logic [NC-1:0]                                 core_apu_gnt_o;
    logic [NC-1:0][APU_NARGS_CPU-1:0][31:0]        core_apu_operands_i;
    logic [NC-1:0][APU_WOP_CPU-1:0]                core_apu_op_i;
    logic [NC-1:0][2:0]                            core_apu_type_i;
    logic [NC-1:0][APU_NDSFLAGS_CPU-1:0]           core_apu_flags_i;
    logic [NC-1:0]                                 core_apu_rvalid_o;
    logic [31:0]                                   core_apu_result_o;
    logic [APU_NUSFLAGS_CPU-1:0]                   core_apu_flags_o;
    logic                                          apu_req_o;
    logic                                          apu_gnt_i;
    logic [APU_NARGS_CPU-1:0][31:0]                apu_operands_o;
    logic [APU_WOP_CPU-1:0]                        apu_op_o;
    logic [2:0]                                    apu_type_o;
    logic [APU_NDSFLAGS_CPU-1:0]                   apu_flags_o;
    logic                                          apu_rvalid_i;
    logic [31:0]                                   apu_result_i;
    logic [APU_NUSFLAGS_CPU-1:0]                   apu_flags_i;
    logic                                          err_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    cv32e40p_apu_arbiter #(
        .NUM_CORES       (NC),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .core_apu_req_i      (core_apu_req_i),
        .core_apu_gnt_o      (core_apu_gnt_o),
        .core_apu_operands_i (core_apu_operands_i),
        .core_apu_op_i       (core_apu_op_i),
        .core_apu_type_i     (core_apu_type_i),
        .core_apu_flags_i    (core_apu_flags_i),
        .core_apu_rvalid_o   (core_apu_rvalid_o),
        .core_apu_result_o   (core_apu_result_o),
        .core_apu_flags_o    (core_apu_flags_o),
        .apu_req_o           (apu_req_o),
        .apu_gnt_i           (apu_gnt_i),
        .apu_operands_o      (apu_operands_o),
        .apu_op_o            (apu_op_o),
        .apu_type_o          (apu_type_o),
        .apu_flags_o         (apu_flags_o),
        .apu_rvalid_i        (apu_rvalid_i),
        .apu_result_i        (apu_result_i),
        .apu_flags_i         (apu_flags_i),
        .err_o               (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_apu_req_i = '0;
        apu_gnt_i      = 1'b0;
        apu_rvalid_i   = 1'b0;
        apu_result_i   = '0;
        apu_flags_i    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        core_apu_op_i       = {6'h2A, 6'h05};
        core_apu_type_i     = {3'd6, 3'd1};
        core_apu_flags_i    = {15'h1234, 15'h0567};
        core_apu_operands_i = {{32'hB2, 32'hB1, 32'hB0}, {32'hA2, 32'hA1, 32'hA0}};
        #2;

        // Reset held with active inputs: no grants, no responses, no error.
        core_apu_req_i = 2'b11;
        apu_gnt_i      = 1'b1;
        apu_rvalid_i   = 1'b1;
        #1;
        check("rst_gnt",    32'(core_apu_gnt_o),    32'h0);
        check("rst_rvalid", 32'(core_apu_rvalid_o), 32'h0);
        check("rst_req",    32'(apu_req_o),         32'h0);
        tick();
        check("rst_err",    32'(err_o),             32'h0);

        // Both cores request continuously; responses arrive two cycles later.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            core_apu_req_i = (c < 4) ? 2'b11 : 2'b00;
            apu_gnt_i      = 1'b1;
            apu_rvalid_i   = (c >= 2);
            apu_result_i   = 32'hA000_0000 + 32'(c);
            apu_flags_i    = 5'(c + 3);
            #1;
            check("alt_gnt",    32'(core_apu_gnt_o),    (c < 4)  ? (32'h1 << (c % 2))       : 32'h0);
            check("alt_rvalid", 32'(core_apu_rvalid_o), (c >= 2) ? (32'h1 << ((c - 2) % 2)) : 32'h0);
            check("alt_result", core_apu_result_o,      32'hA000_0000 + 32'(c));
            check("alt_flags",  32'(core_apu_flags_o),  32'(c + 3));
            if (c < 4) begin
                check("alt_op",  32'(apu_op_o),          (c % 2 == 0) ? 32'h05 : 32'h2A);
                check("alt_opd", apu_operands_o[1],      (c % 2 == 0) ? 32'hA1 : 32'hB1);
            end
            tick();
        end
        idle_inputs();
        #1;
        check("alt_err", 32'(err_o), 32'h0);

        // Only core 1 first; pointer then favours core 0.
        do_reset();
        core_apu_req_i = 2'b10;
        apu_gnt_i      = 1'b1;
        #1;
        check("c1_first_gnt", 32'(core_apu_gnt_o), 32'h2);
        check("c1_first_typ", 32'(apu_type_o),     32'd6);
        tick();
        core_apu_req_i = 2'b11;
        #1;
        check("c0_after_gnt", 32'(core_apu_gnt_o), 32'h1);
        tick();
        #1;
        check("c1_third_gnt", 32'(core_apu_gnt_o), 32'h2);

        // No responses: tracker fills after four grants and blocks requests.
        do_reset();
        core_apu_req_i = 2'b01;
        apu_gnt_i      = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("full_gnt", 32'(core_apu_gnt_o), (c < 4) ? 32'h1 : 32'h0);
            check("full_req", 32'(apu_req_o),      (c < 4) ? 32'h1 : 32'h0);
            tick();
        end
        apu_rvalid_i = 1'b1;
        #1;
        check("full_pop_req",    32'(apu_req_o),         32'h0);
        check("full_pop_gnt",    32'(core_apu_gnt_o),    32'h0);
        check("full_pop_rvalid", 32'(core_apu_rvalid_o), 32'h1);
        tick();
        apu_rvalid_i = 1'b0;
        #1;
        check("full_regnt", 32'(core_apu_gnt_o), 32'h1);
        tick();
        #1;
        check("full_again", 32'(apu_req_o), 32'h0);

        // Spurious response with nothing outstanding.
        do_reset();
        apu_rvalid_i = 1'b1;
        #1;
        check("spur_rvalid", 32'(core_apu_rvalid_o), 32'h0);
        check("spur_err0",   32'(err_o),             32'h0);
        check("idle_op",     32'(apu_op_o),          32'h0);
        check("idle_opd",    apu_operands_o[0],      32'h0);
        tick();
        apu_rvalid_i = 1'b0;
        #1;
        check("spur_err1", 32'(err_o), 32'h1);
        tick();
        tick();
        check("spur_err_sticky", 32'(err_o), 32'h1);

        // Stalled grant must not move the pointer.
        do_reset();
        core_apu_req_i = 2'b01;
        apu_gnt_i      = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_gnt", 32'(core_apu_gnt_o), 32'h0);
            check("stall_req", 32'(apu_req_o),      32'h1);
            tick();
        end
        core_apu_req_i = 2'b11;
        apu_gnt_i      = 1'b1;
        #1;
        check("stall_c0_first", 32'(core_apu_gnt_o), 32'h1);
        tick();
        #1;
        check("stall_c1_next", 32'(core_apu_gnt_o), 32'h2);

        // Reset with three in flight drops the tracked IDs.
        do_reset();
        core_apu_req_i = 2'b01;
        apu_gnt_i      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("mid_gnt", 32'(core_apu_gnt_o), 32'h1);
            tick();
        end
        apu_gnt_i    = 1'b0;
        apu_rvalid_i = 1'b1;
        #1;
        check("mid_pre_rvalid", 32'(core_apu_rvalid_o), 32'h1);
        apu_gnt_i = 1'b1;
        rst_ni    = 1'b0;
        #1;
        check("mid_rst_gnt",    32'(core_apu_gnt_o),    32'h0);
        check("mid_rst_rvalid", 32'(core_apu_rvalid_o), 32'h0);
        tick();
        idle_inputs();
        rst_ni = 1'b1;
        #1;
        check("mid_rst_err0", 32'(err_o), 32'h0);
        apu_rvalid_i = 1'b1;
        #1;
        check("mid_post_rvalid", 32'(core_apu_rvalid_o), 32'h0);
        tick();
        apu_rvalid_i = 1'b0;
        #1;
        check("mid_post_err", 32'(err_o), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
